// File: rtl/mux_scan_pkg.sv
// Shared types and default sizing for the scanning channel mux.
// Holds the state enum and the N / W / DWELL defaults.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam int N_DEF     = 5;
  localparam int W_DEF     = 3;
  localparam int DWELL_DEF = 4;

endpackage

// File: rtl/mux_scan_nw_dwell.sv
// Dwell counter: counts enabled cycles, pulses wrap on the last one.
// Ports: clk, rst (async high), clear, enable -> wrap.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // clear wins, so a wrap is never reported on a clearing cycle
  assign wrap = enable & ~clear & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_nw.sv
// Channel mux with manual select and timed auto-scan, registered output.
// Ports: Clk, Reset, In, S, Load, Mode, Hold -> M, Sel, Valid, Err
// (+ P, even parity of M, when MUX_SCAN_PARITY_EN is defined).
module mux_scan_nw
  import mux_scan_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int DWELL = DWELL_DEF,
  localparam int SW   = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [N*W-1:0] In,
  input  logic [SW-1:0] S,
  input  logic          Load,
  input  logic          Mode,
  input  logic          Hold,
  output logic [W-1:0]  M,
  output logic [SW-1:0] Sel,
  output logic          Valid,
  output logic          Err
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic          P
`endif
);

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  ch;
  logic [SW-1:0] sel_inc;
  logic          sel_ok;
  logic          hold_eff;
  logic          cnt_clr;
  logic          cnt_en;
  logic          wrap;

  assign sel_ok   = int'(sel_q) < N;
  assign hold_eff = Hold & ~Load;

  // out-of-range selects fall back to zero rather than indexing past In
  always_comb begin
    ch = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(sel_q) == k) begin
        ch = In[k*W +: W];
      end
    end
  end

  assign sel_inc = (int'(sel_q) >= N - 1) ? '0 : sel_q + SW'(1);

  // counter only runs while scanning undisturbed; outside SCAN it is
  // held at zero so entering SCAN always starts a fresh dwell
  assign cnt_en  = (state_q == SCAN) & Mode & ~Load & ~Hold;
  assign cnt_clr = Load | (state_q != SCAN);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (Clk),
    .rst    (Reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .wrap   (wrap)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (Load) begin
      sel_d = S;
      if (state_q == IDLE) begin
        state_d = MANUAL;
      end
    end else if (!Hold) begin
      unique case (state_q)
        IDLE: begin
          if (Mode) begin
            state_d = SCAN;
            sel_d   = '0;
          end
        end
        MANUAL: begin
          if (Mode) begin
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (!Mode) begin
            state_d = MANUAL;
          end else if (wrap) begin
            sel_d = sel_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    m_d = m_q;
    if (!hold_eff) begin
      m_d = sel_ok ? ch : '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      m_q     <= m_d;
    end
  end

  assign M     = m_q;
  assign Sel   = sel_q;
  assign Valid = (state_q != IDLE) & sel_ok;
  assign Err   = ~sel_ok;

`ifdef MUX_SCAN_PARITY_EN
  logic p_q, p_d;

  assign p_d = ^m_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p_q <= 1'b0;
    end else begin
      p_q <= p_d;
    end
  end

  assign P = p_q;
`endif

endmodule

// File: tb/tb_mux_scan_nw.sv
// Self-checking bench for mux_scan_nw at N=5, W=3, DWELL=4.
// Table vectors, directed scan/hold/reset runs, random vs model.
module tb_mux_scan_nw;

  localparam int N     = 5;
  localparam int W     = 3;
  localparam int DWELL = 4;
  localparam int SW    = 3;

  logic           Clk;
  logic           Reset;
  logic [N*W-1:0] In;
  logic [SW-1:0]  S;
  logic           Load;
  logic           Mode;
  logic           Hold;
  logic [W-1:0]   M;
  logic [SW-1:0]  Sel;
  logic           Valid;
  logic           Err;
`ifdef MUX_SCAN_PARITY_EN
  logic           P;
`endif

  mux_scan_nw #(
    .N     (N),
    .W     (W),
    .DWELL (DWELL)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .In    (In),
    .S     (S),
    .Load  (Load),
    .Mode  (Mode),
    .Hold  (Hold),
    .M     (M),
    .Sel   (Sel),
    .Valid (Valid),
    .Err   (Err)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .P     (P)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests;
  int failed;

  // reference model: mode 0 idle, 1 manual, 2 scan
  int ms, msel, mcnt, mm;

  function automatic int chan(int k);
    return int'((In >> (k * W)) & 15'h7);
  endfunction

  function automatic int par(int v);
    return (v & 1) ^ ((v >> 1) & 1) ^ ((v >> 2) & 1);
  endfunction

  task automatic model_reset();
    ms = 0; msel = 0; mcnt = 0; mm = 0;
  endtask

  task automatic model_step();
    if (Reset) begin
      model_reset();
      return;
    end
    if (!(Hold && !Load)) mm = (msel < N) ? chan(msel) : 0;
    if (Load) begin
      msel = int'(S);
      mcnt = 0;
      if (ms == 0) ms = 1;
    end else if (!Hold) begin
      if (ms == 0) begin
        if (Mode) begin ms = 2; msel = 0; mcnt = 0; end
      end else if (ms == 1) begin
        if (Mode) begin ms = 2; mcnt = 0; end
      end else begin
        if (!Mode) begin
          ms = 1; mcnt = 0;
        end else if (mcnt == DWELL - 1) begin
          mcnt = 0;
          msel = (msel >= N - 1) ? 0 : msel + 1;
        end else begin
          mcnt++;
        end
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_sel"}, int'(Sel), msel);
    chk({tag, "_m"}, int'(M), mm);
    chk({tag, "_valid"}, int'(Valid), (ms != 0 && msel < N) ? 1 : 0);
    chk({tag, "_err"}, int'(Err), (msel >= N) ? 1 : 0);
`ifdef MUX_SCAN_PARITY_EN
    chk({tag, "_p"}, int'(P), par(mm));
`endif
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic drive(logic ld, logic md, logic hd, int s);
    Load = ld; Mode = md; Hold = hd; S = SW'(s);
  endtask

  typedef struct {
    logic ld;
    logic md;
    logic hd;
    int   s;
    int   sel;
    int   m;
    int   v;
    int   e;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tests = 0;
    failed = 0;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3, 3, 1, 1, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 0, 3, 4, 1, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 6, 6, 4, 0, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 0, 6, 0, 0, 1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 0, 6, 0, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 0, 6, 0, 0, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 0, 6, 0, 0, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 0, 6, 0, 0, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 1, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 0, 0, 1, 1, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 4, 4, 1, 1, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 0, 4, 5, 1, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 0, 4, 5, 1, 0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 7, 7, 5, 0, 1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 0, 7, 0, 0, 1};

    Reset = 1'b1;
    In = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    drive(0, 0, 0, 0);
    model_reset();
    repeat (2) cyc();
    chk("rst_m", int'(M), 0);
    chk("rst_sel", int'(Sel), 0);
    chk("rst_valid", int'(Valid), 0);
    chk("rst_err", int'(Err), 0);
    Reset = 1'b0;

    // table vectors
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ld, tbl[i].md, tbl[i].hd, tbl[i].s);
      cyc();
      chk($sformatf("tbl%0d_sel", i), int'(Sel), tbl[i].sel);
      chk($sformatf("tbl%0d_m", i), int'(M), tbl[i].m);
      chk($sformatf("tbl%0d_valid", i), int'(Valid), tbl[i].v);
      chk($sformatf("tbl%0d_err", i), int'(Err), tbl[i].e);
    end

    // enter scan, then reset asynchronously mid-cycle
    drive(1, 1, 0, 1);
    cyc();
    drive(0, 1, 0, 0);
    repeat (3) begin
      cyc();
      chk_model("prescan");
    end
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("arst_m", int'(M), 0);
    chk("arst_sel", int'(Sel), 0);
    chk("arst_valid", int'(Valid), 0);
    chk("arst_err", int'(Err), 0);
    drive(0, 0, 0, 0);
    cyc();
    Reset = 1'b0;
    repeat (3) begin
      cyc();
      chk("idle_valid", int'(Valid), 0);
      chk_model("idle");
    end

    // scan from idle: Sel steps every DWELL cycles, M one cycle behind
    drive(0, 1, 0, 0);
    for (int t = 1; t <= 24; t++) begin
      cyc();
      chk("scan_sel", int'(Sel), ((t - 1) / 4) % 5);
      chk("scan_m", int'(M), (t == 1) ? 1 : ((t - 2) / 4) % 5 + 1);
      chk_model("scan");
    end

    // run to Sel=2 with M settled, then hold
    begin
      int guard;
      guard = 0;
      while (!(msel == 2 && mm == 3) && guard < 40) begin
        cyc();
        guard++;
      end
      chk("reach_sel2_timeout", (guard < 40) ? 1 : 0, 1);
    end
    drive(0, 1, 1, 0);
    repeat (10) begin
      cyc();
      chk("hold_sel", int'(Sel), 2);
      chk("hold_m", int'(M), 3);
`ifdef MUX_SCAN_PARITY_EN
      chk("hold_p", int'(P), 0);
`endif
      chk_model("hold");
    end
    drive(1, 1, 1, 4);
    cyc();
    chk("holdload_sel", int'(Sel), 4);
    chk_model("holdload");
    drive(0, 1, 0, 0);
    cyc();
    chk("after_m", int'(M), 5);
    chk_model("after");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(0, 59) == 0);
      if (Reset) model_reset();
      Load = ($urandom_range(0, 7) == 0);
      Hold = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) Mode = ~Mode;
      S = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) In = N*W'($urandom);
      cyc();
      chk_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
